ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
Stateful successor to the combinational set-2 scan-code-to-ASCII translator. It consumes raw PS/2 set-2 bytes from the PS/2 receiver and tracks the E0/F0 prefixes, Shift, Ctrl and Caps Lock state. It emits ASCII bytes and VT100 cursor escape sequences through a parametrised show-ahead FIFO with a valid/ready handshake, and feeds the terminal input path of the virtual console.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 4.
ENABLE_ARROWS, 1, when 1, E0-prefixed arrow keys emit ESC [ A/B/C/D; when 0 they are dropped.
UNKNOWN_DROP, 1, when 1, unmapped make codes are dropped; when 0 they emit 8'h2A ('*').

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
scan_valid  in  1  scan_code holds a new byte; one-cycle strobe
scan_code  in  8  raw set-2 byte
scan_ready  out  1  decoder can accept a byte; low while an escape sequence is being emitted
ascii_valid  out  1  FIFO not empty
ascii_code  out  8  FIFO head (show-ahead)
ascii_ready  in  1  consumer pops head when ascii_valid && ascii_ready
shift_held  out  1  either Shift (12, 59) is down
ctrl_held  out  1  either Ctrl (14, E0 14) is down
caps_lock  out  1  Caps Lock toggle state
overflow  out  1  one-cycle pulse when a character or sequence is dropped because the FIFO is full

Behaviour:
- Reset (async, any state): FSM to IDLE; FIFO empty; ascii_valid=0; ascii_code=0; shift_held=0; ctrl_held=0; caps_lock=0; overflow=0; scan_ready=1.
- A byte is accepted on a clk edge where scan_valid && scan_ready. If scan_valid is high while scan_ready is low, the byte is ignored.
- Prefix FSM:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; other -> make(code, ext=1), then IDLE.
  - BRK: any -> break(code, ext=0), then IDLE.
  - EXT_BRK: any -> break(code, ext=1), then IDLE.
  - SEQ: emits the 3 escape bytes, then IDLE.
  - Bytes E1 and AA are ignored in every state except SEQ, and do not change state.
- Modifier tracking: Left and Right Shift are tracked separately, and shift_held is their OR; the same applies to Ctrl. Make sets a key, break clears it.
- Caps Lock (58): caps_lock toggles on make only if Caps is not already down. A caps_down flag is set on make and cleared on break, so typematic repeats do not toggle.
- Modifier and Caps bytes never produce output.
- Character translation uses the standard US set-2 table: digits, letters, punctuation row, space 20, enter 0D, backspace 08, tab 09.
  - Letters: uppercase when shift_held XOR caps_lock.
  - Non-letters: shifted glyph when shift_held only.
  - ctrl_held with a letter: output = uppercase ASCII & 8'h1F (Ctrl-C = 8'h03).
  - Breaks of non-modifier keys produce no output.
- Arrows (ext=1, ENABLE_ARROWS=1): 75 up->A, 72 down->B, 74 right->C, 6B left->D.
  - Requires at least 3 free FIFO entries, counted at the accept edge and including a concurrent pop.
  - If space is available: enter SEQ, scan_ready=0 for 3 cycles, push 1B, 5B, letter on 3 consecutive edges.
  - If space is not available: drop the whole sequence and pulse overflow.
- Latency: byte accepted at edge N -> FIFO push at edge N+1 -> ascii_valid high after edge N+1 if the FIFO was empty.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; the count is unchanged.
  - Push into a full FIFO with no pop: drop the byte, pulse overflow at N+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - ascii_code is stable while ascii_valid && !ascii_ready.
- Extended codes other than arrows and Right Ctrl (E0 14) are treated as unmapped.

Test Plan:
- Sequence 1C, F0 1C -> one output 61 ('a'); no output for the break; shift_held remains 0.
- Sequence 12, 1C, F0 12, 1C -> outputs 41, then 61; shift_held high between 12 and F0 12.
- Sequence 58, 58, F0 58, 1C -> caps_lock=1 after the first 58 only (second 58 is a repeat); output 41. Then 12, 1C -> output 61 (Shift XOR Caps).
- Sequence 14, 21 -> output 03. Sequence E0 75 with ENABLE_ARROWS=1 -> outputs 1B, 5B, 41 on consecutive cycles, scan_ready low for 3 cycles, ascii_ready held at 1.
- Hold ascii_ready=0 and send FIFO_DEPTH+1 letters -> FIFO holds the first 8, overflow pulses once, ascii_code = first letter. Then pop all 8 in order.
- Assert rst mid-SEQ after 1B has been pushed -> all outputs at reset values immediately, FIFO empty, caps_lock=0, next byte 1C -> output 61.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 byte stream to ASCII / VT100 cursor sequence decoder
//
// Tracks the E0/F0 prefixes, both Shift and both Ctrl keys, and Caps Lock.
// Characters and arrow escape sequences go to a show-ahead output FIFO.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   scan_valid, scan_code     raw set-2 byte strobe from the PS/2 receiver
//   scan_ready                low while an escape sequence is being pushed
//   ascii_valid, ascii_code   FIFO not empty, FIFO head
//   ascii_ready               consumer pops the head when ascii_valid is high
//   shift_held, ctrl_held     live modifier state
//   caps_lock                 Caps Lock toggle state
//   overflow                  one-cycle pulse when output is dropped on a full FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter bit ENABLE_ARROWS = 1'b1,
  parameter bit UNKNOWN_DROP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       ascii_valid,
  output logic [7:0] ascii_code,
  input  logic       ascii_ready,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_SEQ     = 3'd4;

  // Returns {mapped, unshifted glyph, shifted glyph} for non-extended codes.
  function automatic logic [16:0] key_map(input logic [7:0] c);
    case (c)
      8'h1C: key_map = {1'b1, 8'h61, 8'h41};  8'h32: key_map = {1'b1, 8'h62, 8'h42};
      8'h21: key_map = {1'b1, 8'h63, 8'h43};  8'h23: key_map = {1'b1, 8'h64, 8'h44};
      8'h24: key_map = {1'b1, 8'h65, 8'h45};  8'h2B: key_map = {1'b1, 8'h66, 8'h46};
      8'h34: key_map = {1'b1, 8'h67, 8'h47};  8'h33: key_map = {1'b1, 8'h68, 8'h48};
      8'h43: key_map = {1'b1, 8'h69, 8'h49};  8'h3B: key_map = {1'b1, 8'h6A, 8'h4A};
      8'h42: key_map = {1'b1, 8'h6B, 8'h4B};  8'h4B: key_map = {1'b1, 8'h6C, 8'h4C};
      8'h3A: key_map = {1'b1, 8'h6D, 8'h4D};  8'h31: key_map = {1'b1, 8'h6E, 8'h4E};
      8'h44: key_map = {1'b1, 8'h6F, 8'h4F};  8'h4D: key_map = {1'b1, 8'h70, 8'h50};
      8'h15: key_map = {1'b1, 8'h71, 8'h51};  8'h2D: key_map = {1'b1, 8'h72, 8'h52};
      8'h1B: key_map = {1'b1, 8'h73, 8'h53};  8'h2C: key_map = {1'b1, 8'h74, 8'h54};
      8'h3C: key_map = {1'b1, 8'h75, 8'h55};  8'h2A: key_map = {1'b1, 8'h76, 8'h56};
      8'h1D: key_map = {1'b1, 8'h77, 8'h57};  8'h22: key_map = {1'b1, 8'h78, 8'h58};
      8'h35: key_map = {1'b1, 8'h79, 8'h59};  8'h1A: key_map = {1'b1, 8'h7A, 8'h5A};
      8'h16: key_map = {1'b1, 8'h31, 8'h21};  8'h1E: key_map = {1'b1, 8'h32, 8'h40};
      8'h26: key_map = {1'b1, 8'h33, 8'h23};  8'h25: key_map = {1'b1, 8'h34, 8'h24};
      8'h2E: key_map = {1'b1, 8'h35, 8'h25};  8'h36: key_map = {1'b1, 8'h36, 8'h5E};
      8'h3D: key_map = {1'b1, 8'h37, 8'h26};  8'h3E: key_map = {1'b1, 8'h38, 8'h2A};
      8'h46: key_map = {1'b1, 8'h39, 8'h28};  8'h45: key_map = {1'b1, 8'h30, 8'h29};
      8'h0E: key_map = {1'b1, 8'h60, 8'h7E};  8'h4E: key_map = {1'b1, 8'h2D, 8'h5F};
      8'h55: key_map = {1'b1, 8'h3D, 8'h2B};  8'h54: key_map = {1'b1, 8'h5B, 8'h7B};
      8'h5B: key_map = {1'b1, 8'h5D, 8'h7D};  8'h5D: key_map = {1'b1, 8'h5C, 8'h7C};
      8'h4C: key_map = {1'b1, 8'h3B, 8'h3A};  8'h52: key_map = {1'b1, 8'h27, 8'h22};
      8'h41: key_map = {1'b1, 8'h2C, 8'h3C};  8'h49: key_map = {1'b1, 8'h2E, 8'h3E};
      8'h4A: key_map = {1'b1, 8'h2F, 8'h3F};  8'h29: key_map = {1'b1, 8'h20, 8'h20};
      8'h5A: key_map = {1'b1, 8'h0D, 8'h0D};  8'h66: key_map = {1'b1, 8'h08, 8'h08};
      8'h0D: key_map = {1'b1, 8'h09, 8'h09};
      default: key_map = 17'h0;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [1:0]    seq_cnt_q, seq_cnt_d;
  logic [7:0]    seq_char_q, seq_char_d;
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic          drop_q, drop_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic          caps_q, caps_d, caps_down_q, caps_down_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          key_ev, key_make, key_ext;
  logic [16:0]   km;
  logic          is_letter, is_arrow, seq_fits;
  logic [7:0]    arrow_char, char_out;
  logic [AW+1:0] used_after;
  logic          fifo_pop, fifo_push, fifo_full, do_write;
  logic [7:0]    fifo_wdata;

  assign shift_held  = lshift_q | rshift_q;
  assign ctrl_held   = lctrl_q | rctrl_q;
  assign caps_lock   = caps_q;
  assign overflow    = overflow_q;
  assign scan_ready  = (state_q != S_SEQ);
  assign ascii_valid = (count_q != '0);
  assign ascii_code  = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_pop   = ascii_valid && ascii_ready;
  assign fifo_push  = push_q || (state_q == S_SEQ);
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_write   = fifo_push && (!fifo_full || fifo_pop);
  assign fifo_wdata = (state_q == S_SEQ) ? ((seq_cnt_q == 2'd0) ? 8'h1B :
                                            (seq_cnt_q == 2'd1) ? 8'h5B : seq_char_q)
                                         : push_data_q;

  // Occupancy once this edge settles, including the pending single-byte push.
  assign used_after = (AW+2)'(count_q) + (AW+2)'(push_q) - (AW+2)'(fifo_pop);
  assign seq_fits   = (used_after <= (AW+2)'(FIFO_DEPTH - 3));

  always_comb begin
    km        = key_map(scan_code);
    is_letter = (km[15:8] >= 8'h61) && (km[15:8] <= 8'h7A);
    if (is_letter) begin
      if (ctrl_held)                   char_out = km[7:0] & 8'h1F;
      else if (shift_held ^ caps_q)    char_out = km[7:0];
      else                             char_out = km[15:8];
    end else begin
      char_out = shift_held ? km[7:0] : km[15:8];
    end
    is_arrow = 1'b1;
    case (scan_code)
      8'h75:   arrow_char = 8'h41;
      8'h72:   arrow_char = 8'h42;
      8'h74:   arrow_char = 8'h43;
      8'h6B:   arrow_char = 8'h44;
      default: begin arrow_char = 8'h00; is_arrow = 1'b0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    seq_cnt_d   = seq_cnt_q;
    seq_char_d  = seq_char_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    drop_d      = 1'b0;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    caps_down_d = caps_down_q;
    key_ev      = 1'b0;
    key_make    = 1'b0;
    key_ext     = 1'b0;

    if (state_q == S_SEQ) begin
      seq_cnt_d = seq_cnt_q + 2'd1;
      if (seq_cnt_q == 2'd2) begin
        state_d   = S_IDLE;
        seq_cnt_d = 2'd0;
      end
    end else if (scan_valid && scan_code != 8'hE1 && scan_code != 8'hAA) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == 8'hE0)      state_d = S_EXT;
          else if (scan_code == 8'hF0) state_d = S_BRK;
          else begin key_ev = 1'b1; key_make = 1'b1; end
        end
        S_EXT: begin
          if (scan_code == 8'hF0) state_d = S_EXT_BRK;
          else begin key_ev = 1'b1; key_make = 1'b1; key_ext = 1'b1; state_d = S_IDLE; end
        end
        S_BRK:     begin key_ev = 1'b1; state_d = S_IDLE; end
        S_EXT_BRK: begin key_ev = 1'b1; key_ext = 1'b1; state_d = S_IDLE; end
        default:   state_d = S_IDLE;
      endcase
    end

    if (key_ev) begin
      if (!key_ext && scan_code == 8'h12)      lshift_d = key_make;
      else if (!key_ext && scan_code == 8'h59) rshift_d = key_make;
      else if (!key_ext && scan_code == 8'h14) lctrl_d  = key_make;
      else if (key_ext && scan_code == 8'h14)  rctrl_d  = key_make;
      else if (!key_ext && scan_code == 8'h58) begin
        // caps_down blocks typematic repeats from toggling again.
        if (key_make && !caps_down_q) caps_d = !caps_q;
        caps_down_d = key_make;
      end else if (key_make) begin
        if (key_ext) begin
          if (is_arrow) begin
            if (ENABLE_ARROWS) begin
              if (seq_fits) begin
                state_d    = S_SEQ;
                seq_cnt_d  = 2'd0;
                seq_char_d = arrow_char;
              end else begin
                drop_d = 1'b1;
              end
            end
          end else if (!UNKNOWN_DROP) begin
            push_d = 1'b1; push_data_d = 8'h2A;
          end
        end else if (km[16]) begin
          push_d = 1'b1; push_data_d = char_out;
        end else if (!UNKNOWN_DROP) begin
          push_d = 1'b1; push_data_d = 8'h2A;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(do_write);
    rd_ptr_d   = rd_ptr_q + AW'(fifo_pop);
    count_d    = count_q + (AW+1)'(do_write) - (AW+1)'(fifo_pop);
    overflow_d = drop_q || (fifo_push && !do_write);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seq_cnt_q   <= 2'd0;
      seq_char_q  <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      drop_q      <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_down_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      seq_char_q  <= seq_char_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      drop_q      <= drop_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      caps_down_q <= caps_down_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= fifo_wdata;
  end

endmodule
